// File: rtl/lw_axi_bch_regs.sv
// Single-beat AXI3 slave and control/status register bank for the BCH codec.
// Terminates the lightweight H2F AXI channels and drives the core start/done handshake.
module lw_axi_bch_regs #(
    parameter int          ADDR_W  = 21,
    parameter int          ID_W    = 12,
    parameter logic [31:0] VERSION = 32'h0BC4_0001
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,

    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,

    output logic [ID_W-1:0]   s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,

    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,

    output logic [ID_W-1:0]   s_axi_rid,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,

    output logic              core_start_o,
    output logic              core_mode_o,
    output logic [31:0]       core_data_o,
    input  logic              core_done_i,
    input  logic [31:0]       core_result_i,
    input  logic [3:0]        core_errcnt_i
);

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_DATA_IN  = 3'd2;
    localparam logic [2:0] REG_DATA_OUT = 3'd3;
    localparam logic [2:0] REG_SCRATCH  = 3'd4;
    localparam logic [2:0] REG_ID       = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Readys stay low until the first edge after reset release.
    logic              rst_done_reg;

    logic              aw_held_reg;
    logic              w_held_reg;
    logic [ID_W-1:0]   awid_hold_reg;
    logic [2:0]        awidx_hold_reg;
    logic [31:0]       wdata_hold_reg;
    logic [3:0]        wstrb_hold_reg;

    logic              bvalid_reg;
    logic [ID_W-1:0]   bid_reg;
    logic [1:0]        bresp_reg;

    logic              rvalid_reg;
    logic [ID_W-1:0]   rid_reg;
    logic [31:0]       rdata_reg;
    logic [1:0]        rresp_reg;

    logic              mode_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              start_ovr_reg;
    logic              core_start_reg;
    logic [3:0]        errcnt_reg;
    logic [31:0]       data_in_reg;
    logic [31:0]       data_out_reg;
    logic [31:0]       scratch_reg;

    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              b_hs;
    logic              r_hs;
    logic              commit;
    logic              wr_ctrl;
    logic              wr_status;
    logic              wr_data_in;
    logic              wr_scratch;
    logic              start_req;
    logic              done_evt;
    logic              start_accept;
    logic              start_drop;

    logic [31:0]       data_in_next;
    logic [31:0]       scratch_next;
    logic              busy_next;
    logic              done_next;
    logic              start_ovr_next;
    logic              mode_next;
    logic [1:0]        bresp_next;
    logic [31:0]       rdata_next;
    logic [1:0]        rresp_next;

    // Only address bits [4:2] decode; the rest alias the bank.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[ADDR_W-1:5], s_axi_awaddr[1:0],
                                s_axi_araddr[ADDR_W-1:5], s_axi_araddr[1:0]};

    assign s_axi_awready = rst_done_reg && !aw_held_reg;
    assign s_axi_wready  = rst_done_reg && !w_held_reg;
    assign s_axi_arready = rst_done_reg && !rvalid_reg;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign b_hs   = bvalid_reg && s_axi_bready;
    assign r_hs   = rvalid_reg && s_axi_rready;
    assign commit = aw_held_reg && w_held_reg && (!bvalid_reg || s_axi_bready);

    assign wr_ctrl    = commit && (awidx_hold_reg == REG_CTRL);
    assign wr_status  = commit && (awidx_hold_reg == REG_STATUS) && wstrb_hold_reg[0];
    assign wr_data_in = commit && (awidx_hold_reg == REG_DATA_IN);
    assign wr_scratch = commit && (awidx_hold_reg == REG_SCRATCH);

    // Completion is handled before a same-cycle start, so that start sees the core idle.
    assign start_req    = wr_ctrl && wstrb_hold_reg[0] && wdata_hold_reg[0];
    assign done_evt     = core_done_i && busy_reg;
    assign start_accept = start_req && (!busy_reg || done_evt);
    assign start_drop   = start_req && busy_reg && !done_evt;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign data_in_next[gi*8 +: 8] = (wr_data_in && wstrb_hold_reg[gi]) ?
                                             wdata_hold_reg[gi*8 +: 8] : data_in_reg[gi*8 +: 8];
            assign scratch_next[gi*8 +: 8] = (wr_scratch && wstrb_hold_reg[gi]) ?
                                             wdata_hold_reg[gi*8 +: 8] : scratch_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        mode_next      = mode_reg;
        busy_next      = busy_reg;
        done_next      = done_reg;
        start_ovr_next = start_ovr_reg;

        if (wr_ctrl && wstrb_hold_reg[0]) begin
            mode_next = wdata_hold_reg[1];
        end

        if (start_accept) begin
            busy_next = 1'b1;
        end else if (done_evt) begin
            busy_next = 1'b0;
        end

        // A completion in the same cycle as a W1C keeps DONE set.
        if (done_evt) begin
            done_next = 1'b1;
        end else if (wr_status && wdata_hold_reg[1]) begin
            done_next = 1'b0;
        end

        if (start_drop) begin
            start_ovr_next = 1'b1;
        end else if (wr_status && wdata_hold_reg[2]) begin
            start_ovr_next = 1'b0;
        end
    end

    always_comb begin
        bresp_next = (awidx_hold_reg[2:1] == 2'b11) ? RESP_SLVERR : RESP_OKAY;
    end

    always_comb begin
        rdata_next = 32'h0;
        rresp_next = RESP_OKAY;
        case (s_axi_araddr[4:2])
            REG_CTRL:     rdata_next = {30'h0, mode_reg, 1'b0};
            REG_STATUS:   rdata_next = {20'h0, errcnt_reg, 5'h0, start_ovr_reg, done_reg, busy_reg};
            REG_DATA_IN:  rdata_next = data_in_reg;
            REG_DATA_OUT: rdata_next = data_out_reg;
            REG_SCRATCH:  rdata_next = scratch_reg;
            REG_ID:       rdata_next = VERSION;
            default:      rresp_next = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_reg   <= 1'b0;
            aw_held_reg    <= 1'b0;
            w_held_reg     <= 1'b0;
            awid_hold_reg  <= '0;
            awidx_hold_reg <= 3'h0;
            wdata_hold_reg <= 32'h0;
            wstrb_hold_reg <= 4'h0;
            bvalid_reg     <= 1'b0;
            bid_reg        <= '0;
            bresp_reg      <= RESP_OKAY;
        end else begin
            rst_done_reg <= 1'b1;

            if (aw_hs) begin
                aw_held_reg    <= 1'b1;
                awid_hold_reg  <= s_axi_awid;
                awidx_hold_reg <= s_axi_awaddr[4:2];
            end else if (commit) begin
                aw_held_reg <= 1'b0;
            end

            if (w_hs) begin
                w_held_reg     <= 1'b1;
                wdata_hold_reg <= s_axi_wdata;
                wstrb_hold_reg <= s_axi_wstrb;
            end else if (commit) begin
                w_held_reg <= 1'b0;
            end

            if (commit) begin
                bvalid_reg <= 1'b1;
                bid_reg    <= awid_hold_reg;
                bresp_reg  <= bresp_next;
            end else if (b_hs) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_reg <= 1'b0;
            rid_reg    <= '0;
            rdata_reg  <= 32'h0;
            rresp_reg  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rid_reg    <= s_axi_arid;
            rdata_reg  <= rdata_next;
            rresp_reg  <= rresp_next;
        end else if (r_hs) begin
            rvalid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            start_ovr_reg  <= 1'b0;
            core_start_reg <= 1'b0;
            errcnt_reg     <= 4'h0;
            data_in_reg    <= 32'h0;
            data_out_reg   <= 32'h0;
            scratch_reg    <= 32'h0;
        end else begin
            mode_reg       <= mode_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            start_ovr_reg  <= start_ovr_next;
            core_start_reg <= start_accept;
            data_in_reg    <= data_in_next;
            scratch_reg    <= scratch_next;
            if (done_evt) begin
                data_out_reg <= core_result_i;
                errcnt_reg   <= core_errcnt_i;
            end
        end
    end

    assign s_axi_bvalid = bvalid_reg;
    assign s_axi_bid    = bid_reg;
    assign s_axi_bresp  = bresp_reg;
    assign s_axi_rvalid = rvalid_reg;
    assign s_axi_rlast  = rvalid_reg;
    assign s_axi_rid    = rid_reg;
    assign s_axi_rdata  = rdata_reg;
    assign s_axi_rresp  = rresp_reg;
    assign core_start_o = core_start_reg;
    assign core_mode_o  = mode_reg;
    assign core_data_o  = data_in_reg;

endmodule

// File: tb/tb_lw_axi_bch_regs.sv
// Directed bench for lw_axi_bch_regs: AXI write/read paths, register map and core handshake.
module tb_lw_axi_bch_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] awid;
    logic [20:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [11:0] bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [11:0] arid;
    logic [20:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [11:0] rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        core_start;
    logic        core_mode;
    logic [31:0] core_data;
    logic        core_done;
    logic [31:0] core_result;
    logic [3:0]  core_errcnt;

    int          vectors = 0;
    int          miscompares = 0;
    int          pulses = 0;
    logic        start_at_b;
    logic [11:0] got_id;
    logic [1:0]  got_resp;
    logic [31:0] got_data;
    logic        got_last;

    lw_axi_bch_regs dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awid    (awid),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bid     (bid),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_arid    (arid),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rid     (rid),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rlast   (rlast),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .core_start_o  (core_start),
        .core_mode_o   (core_mode),
        .core_data_o   (core_data),
        .core_done_i   (core_done),
        .core_result_i (core_result),
        .core_errcnt_i (core_errcnt)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (core_start) pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_done(input logic [31:0] res, input logic [3:0] err);
        core_done = 1'b1; core_result = res; core_errcnt = err;
        @(posedge clk); #1;
        core_done = 1'b0;
    endtask

    // Optional core_done pulse lands on the commit edge.
    task automatic axi_write(input logic [11:0] id, input logic [20:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic with_done, input logic [31:0] res,
                             input logic [3:0] err, output logic [11:0] bid_o, output logic [1:0] bresp_o);
        int n;
        bit aw_ok, w_ok, aw_hs, w_hs;
        awid = id; awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        aw_ok = 0; w_ok = 0; n = 0;
        while (!(aw_ok && w_ok) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1; n++;
            if (aw_hs) begin awvalid = 1'b0; aw_ok = 1; end
            if (w_hs)  begin wvalid = 1'b0;  w_ok = 1;  end
        end
        check("aw_w_accepted", 32'(aw_ok && w_ok), 32'h1);
        awvalid = 1'b0; wvalid = 1'b0;
        if (with_done) begin
            core_done = 1'b1; core_result = res; core_errcnt = err;
        end
        bready = 1'b1; n = 0;
        while (!bvalid && n < 20) begin
            @(posedge clk); #1; n++;
            core_done = 1'b0;
        end
        check("bvalid_seen", 32'(bvalid), 32'h1);
        start_at_b = core_start;
        bid_o = bid; bresp_o = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] id, input logic [20:0] addr, output logic [31:0] d,
                            output logic [11:0] rid_o, output logic [1:0] resp_o, output logic last_o);
        int n;
        bit hs;
        arid = id; araddr = addr; arvalid = 1'b1; hs = 0; n = 0;
        while (!hs && n < 20) begin
            hs = arready;
            @(posedge clk); #1; n++;
        end
        arvalid = 1'b0;
        rready = 1'b1; n = 0;
        while (!rvalid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("rvalid_seen", 32'(rvalid), 32'h1);
        d = rdata; rid_o = rid; resp_o = rresp; last_o = rlast;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        awid = '0; awaddr = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        core_done = 1'b0; core_result = '0; core_errcnt = '0;

        // Outputs during reset
        #1;
        check("rst_awready", 32'(awready), 32'h0);
        check("rst_wready", 32'(wready), 32'h0);
        check("rst_arready", 32'(arready), 32'h0);
        check("rst_bvalid", 32'(bvalid), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rlast", 32'(rlast), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_bid_rid", 32'({bid, rid}), 32'h0);
        check("rst_core_outs", 32'({core_start, core_mode}), 32'h0);
        check("rst_core_data", core_data, 32'h0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("ready_before_edge", 32'(arready), 32'h0);
        @(posedge clk); #1;
        check("ready_after_rel", 32'({awready, wready, arready}), 32'h7);

        // Byte-strobed scratch write, read back with ID echo
        axi_write(12'h3A5, 21'h10, 32'hDEADBEEF, 4'b0101, 1'b0, 32'h0, 4'h0, got_id, got_resp);
        check("t1_bid", 32'(got_id), 32'h3A5);
        check("t1_bresp", 32'(got_resp), 32'h0);
        axi_read(12'h011, 21'h10, got_data, got_id, got_resp, got_last);
        check("t1_rdata", got_data, 32'h00AD00EF);
        check("t1_rid", 32'(got_id), 32'h011);
        check("t1_rresp", 32'(got_resp), 32'h0);
        check("t1_rlast", 32'(got_last), 32'h1);

        // W three cycles ahead of AW, then B back-pressured
        wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        check("t2_wready_held", 32'(wready), 32'h0);
        check("t2_awready_free", 32'(awready), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        check("t2_wready_still", 32'(wready), 32'h0);
        check("t2_no_early_b", 32'(bvalid), 32'h0);
        awid = 12'h055; awaddr = 21'h10; awvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b0;
        check("t2_awready_held", 32'(awready), 32'h0);
        @(posedge clk); #1;
        check("t2_bvalid", 32'(bvalid), 32'h1);
        check("t2_bid", 32'(bid), 32'h055);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("t2_bvalid_hold", 32'(bvalid), 32'h1);
            check("t2_bid_hold", 32'(bid), 32'h055);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("t2_b_done", 32'(bvalid), 32'h0);
        @(posedge clk); #1;
        check("t2_single_commit", 32'(bvalid), 32'h0);
        axi_read(12'h001, 21'h10, got_data, got_id, got_resp, got_last);
        check("t2_scratch", got_data, 32'h11223344);

        // Encode start and completion
        axi_write(12'h002, 21'h08, 32'h12345678, 4'hF, 1'b0, 32'h0, 4'h0, got_id, got_resp);
        check("t3_core_data", core_data, 32'h12345678);
        axi_write(12'h003, 21'h00, 32'h3, 4'hF, 1'b0, 32'h0, 4'h0, got_id, got_resp);
        check("t3_start_at_b", 32'(start_at_b), 32'h1);
        check("t3_mode", 32'(core_mode), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        check("t3_one_pulse", 32'(pulses), 32'd1);
        axi_read(12'h004, 21'h04, got_data, got_id, got_resp, got_last);
        check("t3_status_busy", got_data, 32'h1);
        axi_read(12'h005, 21'h00, got_data, got_id, got_resp, got_last);
        check("t3_ctrl_read", got_data, 32'h2);
        pulse_done(32'hCAFEF00D, 4'd2);
        axi_read(12'h006, 21'h04, got_data, got_id, got_resp, got_last);
        check("t3_status_done", got_data, 32'h202);
        axi_read(12'h007, 21'h0C, got_data, got_id, got_resp, got_last);
        check("t3_data_out", got_data, 32'hCAFEF00D);

        // Start while busy, W1C, and coincident events
        axi_write(12'h008, 21'h00, 32'h1, 4'hF, 1'b0, 32'h0, 4'h0, got_id, got_resp);
        check("t4_pulse2", 32'(pulses), 32'd2);
        check("t4_mode0", 32'(core_mode), 32'h0);
        axi_read(12'h009, 21'h04, got_data, got_id, got_resp, got_last);
        check("t4_status_203", got_data, 32'h203);
        axi_write(12'h00A, 21'h00, 32'h1, 4'hF, 1'b0, 32'h0, 4'h0, got_id, got_resp);
        check("t4_dropped", 32'(pulses), 32'd2);
        axi_read(12'h00B, 21'h04, got_data, got_id, got_resp, got_last);
        check("t4_status_ovr", got_data, 32'h207);
        pulse_done(32'h0000_1111, 4'd5);
        axi_read(12'h00C, 21'h04, got_data, got_id, got_resp, got_last);
        check("t4_status_506", got_data, 32'h506);
        axi_write(12'h00D, 21'h04, 32'h6, 4'hF, 1'b0, 32'h0, 4'h0, got_id, got_resp);
        check("t4_w1c_bresp", 32'(got_resp), 32'h0);
        axi_read(12'h00E, 21'h04, got_data, got_id, got_resp, got_last);
        check("t4_status_cleared", got_data, 32'h500);
        axi_write(12'h00F, 21'h00, 32'h1, 4'hF, 1'b0, 32'h0, 4'h0, got_id, got_resp);
        check("t4_pulse3", 32'(pulses), 32'd3);
        axi_write(12'h010, 21'h04, 32'h2, 4'hF, 1'b1, 32'h0000_00AA, 4'd1, got_id, got_resp);
        axi_read(12'h011, 21'h04, got_data, got_id, got_resp, got_last);
        check("t4_set_wins", got_data, 32'h102);
        axi_write(12'h012, 21'h00, 32'h1, 4'hF, 1'b0, 32'h0, 4'h0, got_id, got_resp);
        check("t4_pulse4", 32'(pulses), 32'd4);
        axi_write(12'h013, 21'h00, 32'h1, 4'hF, 1'b1, 32'hBBBB0000, 4'd3, got_id, got_resp);
        check("t4_done_then_start", 32'(pulses), 32'd5);
        axi_read(12'h014, 21'h04, got_data, got_id, got_resp, got_last);
        check("t4_status_303", got_data, 32'h303);
        axi_write(12'h015, 21'h04, 32'h2, 4'b1110, 1'b0, 32'h0, 4'h0, got_id, got_resp);
        axi_read(12'h016, 21'h04, got_data, got_id, got_resp, got_last);
        check("t4_w1c_needs_strb0", got_data, 32'h303);

        // Unmapped offsets, ID, aliasing, RO writes
        axi_read(12'h020, 21'h18, got_data, got_id, got_resp, got_last);
        check("t5_unmapped_rdata", got_data, 32'h0);
        check("t5_unmapped_rresp", 32'(got_resp), 32'h2);
        axi_write(12'h021, 21'h1C, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 4'h0, got_id, got_resp);
        check("t5_unmapped_bresp", 32'(got_resp), 32'h2);
        axi_read(12'h022, 21'h14, got_data, got_id, got_resp, got_last);
        check("t5_id", got_data, 32'h0BC40001);
        check("t5_id_rresp", 32'(got_resp), 32'h0);
        axi_read(12'h023, 21'h30, got_data, got_id, got_resp, got_last);
        check("t5_alias_scratch", got_data, 32'h11223344);
        axi_write(12'h024, 21'h0C, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 4'h0, got_id, got_resp);
        check("t5_ro_bresp", 32'(got_resp), 32'h0);
        axi_read(12'h025, 21'h0C, got_data, got_id, got_resp, got_last);
        check("t5_ro_unchanged", got_data, 32'hBBBB0000);

        // Reset while busy with a read response pending
        arid = 12'h007; araddr = 21'h04; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("t6_rvalid_up", 32'({rvalid, rlast}), 32'h3);
        #5 rst_n = 1'b0;
        #1;
        check("t6_rvalid_drop", 32'({rvalid, rlast}), 32'h0);
        check("t6_rdata_rid", rdata | 32'(rid), 32'h0);
        check("t6_readys_low", 32'({awready, wready, arready, bvalid}), 32'h0);
        check("t6_core_outs", core_data | 32'({core_start, core_mode}), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_readys_back", 32'({awready, wready, arready}), 32'h7);
        pulse_done(32'h5555_5555, 4'd7);
        axi_read(12'h030, 21'h04, got_data, got_id, got_resp, got_last);
        check("t6_status_zero", got_data, 32'h0);
        axi_read(12'h031, 21'h0C, got_data, got_id, got_resp, got_last);
        check("t6_data_out_zero", got_data, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
